// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and write-source encodings for the register-file write port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned PC_W_DEF   = 32;

    typedef enum logic {
        WB_SRC_PIPE = 1'b0,
        WB_SRC_LU   = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_res_fifo.sv
// Synchronous FIFO for long-latency results; the head is visible one cycle after the push,
// and nothing passes through combinationally.
module wb_res_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            wdata_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            rdata_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
        else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback has priority, long-latency results
// drain from a FIFO into free slots or via a forced stall. Optional WB_ARB_PERF_EN adds counters.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_DEF,
    parameter int unsigned REG_AW       = REG_AW_DEF,
    parameter int unsigned PC_W         = PC_W_DEF,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   wb_pc_i,
    input  logic              wb_rd_wr_en_i,
    input  logic [REG_AW-1:0] wb_rd_addr_i,
    input  logic [XLEN-1:0]   wb_rd_reg_data_i,
    input  logic              lu_valid_i,
    output logic              lu_ready_o,
    input  logic [REG_AW-1:0] lu_rd_addr_i,
    input  logic [XLEN-1:0]   lu_rd_data_i,
    output logic              stall_o,
    output logic              rf_wr_en_o,
    output logic [REG_AW-1:0] rf_wr_addr_o,
    output logic [XLEN-1:0]   rf_wr_data_o,
    output logic              rf_wr_src_o,
    output logic [PC_W-1:0]   wb_pc_o
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt_o,
    output logic [31:0]       perf_lu_wr_cnt_o
`endif
);

    localparam int unsigned EW = REG_AW + XLEN;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic              fifo_full, fifo_empty, push, pop, pipe_busy;
    logic [EW-1:0]     fifo_head;
    logic [CW-1:0]     fifo_count;
    logic [SW-1:0]     starve_q, starve_d;

    logic              rf_en_q, rf_en_d;
    logic [REG_AW-1:0] rf_addr_q, rf_addr_d;
    logic [XLEN-1:0]   rf_data_q, rf_data_d;
    wb_src_e           rf_src_q, rf_src_d;
    logic [PC_W-1:0]   pc_q, pc_d;

    wb_res_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i ({lu_rd_addr_i, lu_rd_data_i}),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign lu_ready_o = !fifo_full;
    // x0 results complete the handshake but are never stored.
    assign push       = lu_valid_i && lu_ready_o && (lu_rd_addr_i != '0);
    assign pipe_busy  = wb_rd_wr_en_i && (wb_rd_addr_i != '0);
    assign stall_o    = (starve_q == SW'(STARVE_LIMIT)) && !fifo_empty;

    always_comb begin
        pop       = 1'b0;
        rf_en_d   = 1'b0;
        rf_addr_d = '0;
        rf_data_d = '0;
        rf_src_d  = WB_SRC_PIPE;
        pc_d      = '0;
        if (stall_o || (!pipe_busy && !fifo_empty)) begin
            pop       = 1'b1;
            rf_en_d   = 1'b1;
            rf_addr_d = fifo_head[EW-1:XLEN];
            rf_data_d = fifo_head[XLEN-1:0];
            rf_src_d  = WB_SRC_LU;
        end else if (pipe_busy) begin
            rf_en_d   = 1'b1;
            rf_addr_d = wb_rd_addr_i;
            rf_data_d = wb_rd_reg_data_i;
            pc_d      = wb_pc_i;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_count == '0 || pop)
            starve_d = '0;
        else if (starve_q != SW'(STARVE_LIMIT))
            starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q  <= '0;
            rf_en_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            rf_src_q  <= WB_SRC_PIPE;
            pc_q      <= '0;
        end else begin
            starve_q  <= starve_d;
            rf_en_q   <= rf_en_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            rf_src_q  <= rf_src_d;
            pc_q      <= pc_d;
        end
    end

    assign rf_wr_en_o   = rf_en_q;
    assign rf_wr_addr_o = rf_addr_q;
    assign rf_wr_data_o = rf_data_q;
    assign rf_wr_src_o  = rf_src_q;
    assign wb_pc_o      = pc_q;

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_stall_q, perf_lu_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_lu_q    <= '0;
        end else begin
            if (stall_o) perf_stall_q <= perf_stall_q + 32'd1;
            if (pop)     perf_lu_q    <= perf_lu_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_lu_wr_cnt_o = perf_lu_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations (default parameters).
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_pc_i;
    logic        wb_rd_wr_en_i;
    logic [4:0]  wb_rd_addr_i;
    logic [31:0] wb_rd_reg_data_i;
    logic        lu_valid_i;
    logic        lu_ready_o;
    logic [4:0]  lu_rd_addr_i;
    logic [31:0] lu_rd_data_i;
    logic        stall_o;
    logic        rf_wr_en_o;
    logic [4:0]  rf_wr_addr_o;
    logic [31:0] rf_wr_data_o;
    logic        rf_wr_src_o;
    logic [31:0] wb_pc_o;
`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_stall_cnt_o;
    logic [31:0] perf_lu_wr_cnt_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .XLEN         (32),
        .REG_AW       (5),
        .PC_W         (32),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .wb_pc_i          (wb_pc_i),
        .wb_rd_wr_en_i    (wb_rd_wr_en_i),
        .wb_rd_addr_i     (wb_rd_addr_i),
        .wb_rd_reg_data_i (wb_rd_reg_data_i),
        .lu_valid_i       (lu_valid_i),
        .lu_ready_o       (lu_ready_o),
        .lu_rd_addr_i     (lu_rd_addr_i),
        .lu_rd_data_i     (lu_rd_data_i),
        .stall_o          (stall_o),
        .rf_wr_en_o       (rf_wr_en_o),
        .rf_wr_addr_o     (rf_wr_addr_o),
        .rf_wr_data_o     (rf_wr_data_o),
        .rf_wr_src_o      (rf_wr_src_o),
        .wb_pc_o          (wb_pc_o)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_lu_wr_cnt_o (perf_lu_wr_cnt_o)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [4:0] addr,
                          input logic [31:0] data, input logic src, input logic [31:0] pc);
        chk({tag, ".en"},   64'(rf_wr_en_o),   64'(en));
        chk({tag, ".addr"}, 64'(rf_wr_addr_o), 64'(addr));
        chk({tag, ".data"}, 64'(rf_wr_data_o), 64'(data));
        chk({tag, ".src"},  64'(rf_wr_src_o),  64'(src));
        chk({tag, ".pc"},   64'(wb_pc_o),      64'(pc));
    endtask

    task automatic pipe(input logic en, input logic [4:0] rd, input logic [31:0] d, input logic [31:0] pc);
        wb_rd_wr_en_i    = en;
        wb_rd_addr_i     = rd;
        wb_rd_reg_data_i = d;
        wb_pc_i          = pc;
    endtask

    task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lu_valid_i   = v;
        lu_rd_addr_i = rd;
        lu_rd_data_i = d;
    endtask

    initial begin
        rst = 1'b1;
        pipe(1'b0, 5'd0, 32'h0, 32'h0);
        lu(1'b0, 5'd0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        chk_wr("reset", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        chk("reset.ready", 64'(lu_ready_o), 64'd1);
        chk("reset.stall", 64'(stall_o), 64'd0);

        // Pipeline only
        pipe(1'b1, 5'd5, 32'hDEADBEEF, 32'h100);
        tick();
        chk_wr("pipe", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h100);
        chk("pipe.ready", 64'(lu_ready_o), 64'd1);
        pipe(1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        chk("pipe.idle", 64'(rf_wr_en_o), 64'd0);

        // LU result into idle slot: write two edges after acceptance
        lu(1'b1, 5'd7, 32'h12);
        tick();
        lu(1'b0, 5'd0, 32'h0);
        chk("lu.n1.en", 64'(rf_wr_en_o), 64'd0);
        chk("lu.n1.ready", 64'(lu_ready_o), 64'd1);
        tick();
        chk_wr("lu.n2", 1'b1, 5'd7, 32'h12, 1'b1, 32'h0);
        tick();
        chk("lu.n3.en", 64'(rf_wr_en_o), 64'd0);

        // Starvation: pipeline busy every cycle
        pipe(1'b1, 5'd1, 32'hAAAA0000, 32'h200);
        lu(1'b1, 5'd3, 32'h33);
        tick();
        lu(1'b0, 5'd0, 32'h0);
        chk_wr("starve.e0", 1'b1, 5'd1, 32'hAAAA0000, 1'b0, 32'h200);
        chk("starve.e0.stall", 64'(stall_o), 64'd0);
        for (int unsigned i = 1; i <= 4; i++) begin
            pipe(1'b1, 5'd1, 32'hAAAA0000 + i, 32'h200 + 4 * i);
            tick();
            chk("starve.src", 64'(rf_wr_src_o), 64'd0);
            chk("starve.stall", 64'(stall_o), (i == 4) ? 64'd1 : 64'd0);
        end
        pipe(1'b1, 5'd1, 32'hAAAA0005, 32'h214);
        tick();
        chk_wr("starve.lu", 1'b1, 5'd3, 32'h33, 1'b1, 32'h0);
        chk("starve.clear", 64'(stall_o), 64'd0);
        tick();
        chk_wr("starve.resume", 1'b1, 5'd1, 32'hAAAA0005, 1'b0, 32'h214);

        // Full FIFO with ordering
        pipe(1'b1, 5'd2, 32'h22, 32'h300);
        lu(1'b1, 5'd10, 32'hA0);
        tick();
        chk("full.e0.ready", 64'(lu_ready_o), 64'd1);
        lu(1'b1, 5'd11, 32'hB0);
        tick();
        chk("full.e1.ready", 64'(lu_ready_o), 64'd0);
        lu(1'b1, 5'd12, 32'hC0);
        tick();
        chk("full.e2.ready", 64'(lu_ready_o), 64'd0);
        chk("full.e2.src", 64'(rf_wr_src_o), 64'd0);
        chk("full.e2.stall", 64'(stall_o), 64'd0);
        pipe(1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        chk_wr("full.a", 1'b1, 5'd10, 32'hA0, 1'b1, 32'h0);
        chk("full.e3.ready", 64'(lu_ready_o), 64'd1);
        tick();
        lu(1'b0, 5'd0, 32'h0);
        chk_wr("full.b", 1'b1, 5'd11, 32'hB0, 1'b1, 32'h0);
        tick();
        chk_wr("full.c", 1'b1, 5'd12, 32'hC0, 1'b1, 32'h0);
        tick();
        chk("full.drained", 64'(rf_wr_en_o), 64'd0);

        // x0 handling
        pipe(1'b1, 5'd4, 32'h44, 32'h400);
        lu(1'b1, 5'd9, 32'h99);
        tick();
        lu(1'b0, 5'd0, 32'h0);
        pipe(1'b1, 5'd0, 32'h55, 32'h404);
        tick();
        chk_wr("x0.pipe", 1'b1, 5'd9, 32'h99, 1'b1, 32'h0);
        tick();
        chk("x0.pipe.nowr", 64'(rf_wr_en_o), 64'd0);
        pipe(1'b0, 5'd0, 32'h0, 32'h0);
        lu(1'b1, 5'd0, 32'hFF);
        tick();
        lu(1'b0, 5'd0, 32'h0);
        chk("x0.lu.ready", 64'(lu_ready_o), 64'd1);
        tick();
        chk("x0.lu.nowr1", 64'(rf_wr_en_o), 64'd0);
        tick();
        chk("x0.lu.nowr2", 64'(rf_wr_en_o), 64'd0);

        // Reset mid-operation with two buffered entries
        pipe(1'b1, 5'd6, 32'h66, 32'h500);
        lu(1'b1, 5'd13, 32'hD0);
        tick();
        lu(1'b1, 5'd14, 32'hE0);
        tick();
        lu(1'b0, 5'd0, 32'h0);
        chk("rst.full", 64'(lu_ready_o), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pipe(1'b0, 5'd0, 32'h0, 32'h0);
        chk_wr("rst.mid", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        chk("rst.mid.ready", 64'(lu_ready_o), 64'd1);
        chk("rst.mid.stall", 64'(stall_o), 64'd0);
        tick();
        chk("rst.nostale1", 64'(rf_wr_en_o), 64'd0);
        tick();
        chk("rst.nostale2", 64'(rf_wr_en_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback stage, which has priority and no backpressure;
  - a long-latency result source (divider / LSU miss) using a valid/ready handshake.
- Long-latency results are buffered in a small FIFO and drained into idle pipeline slots.
- A starvation counter forces a pipeline stall when the FIFO head has waited too long.
- Sits between the writeback stage and the register file.

Parameters:
- XLEN, 32, register data width
- REG_AW, 5, register address width
- PC_W, 32, PC width
- FIFO_DEPTH, 2, long-result buffer entries; power of 2, >=2
- STARVE_LIMIT, 4, wait cycles of a non-empty FIFO before a forced stall; >=1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_pc_i  in  PC_W  PC of pipeline writeback instruction
- wb_rd_wr_en_i  in  1  pipeline write request
- wb_rd_addr_i  in  REG_AW  pipeline destination register
- wb_rd_reg_data_i  in  XLEN  pipeline write data
- lu_valid_i  in  1  long-latency result valid
- lu_ready_o  out  1  arbiter can accept long-latency result
- lu_rd_addr_i  in  REG_AW  long-latency destination register
- lu_rd_data_i  in  XLEN  long-latency result data
- stall_o  out  1  pipeline must hold its writeback inputs this cycle
- rf_wr_en_o  out  1  register-file write enable (registered)
- rf_wr_addr_o  out  REG_AW  register-file write address (registered)
- rf_wr_data_o  out  XLEN  register-file write data (registered)
- rf_wr_src_o  out  1  0 = pipeline, 1 = long-latency (registered)
- wb_pc_o  out  PC_W  PC of the registered pipeline write; 0 when src=1

Behaviour:
- Interface (decided): one clock clk; reset rst is synchronous and active-high.
- Reset: every rf_* output, wb_pc_o, FIFO pointers/count and starvation counter go to 0. lu_ready_o is 1 in the first cycle after reset. stall_o is 0.
- A reset asserted mid-operation discards all buffered entries; no write is issued in the reset cycle.
- Pipeline slot is busy when wb_rd_wr_en_i=1 and wb_rd_addr_i!=0. An x0 request counts as a free slot and is never written.
- Priority each cycle, with the result registered to rf_* at the next edge:
  1. stall_o=1: FIFO head wins; pipeline inputs are ignored and must be held by the pipeline.
  2. Pipeline slot busy: pipeline wins; rf_wr_src_o=0; wb_pc_o=wb_pc_i.
  3. FIFO non-empty: head pops; rf_wr_src_o=1.
  4. Otherwise: rf_wr_en_o=0 next cycle.
- Latency:
  - pipeline request at cycle N appears on rf_* at N+1;
  - long-latency result accepted at N is at the FIFO head at N+1, written at N+2 at the earliest.
- Handshake:
  - lu_ready_o = !full, driven from registered count only; there is no same-cycle pass-through when full even if a pop occurs.
  - A push happens on lu_valid_i & lu_ready_o.
  - lu_rd_addr_i=0 is accepted and dropped (no push).
  - Simultaneous push and pop: count unchanged; pointers wrap modulo FIFO_DEPTH.
- Starvation counter:
  - increments each cycle the FIFO is non-empty and no pop occurs;
  - clears on a pop or when the FIFO is empty;
  - saturates at STARVE_LIMIT.
- stall_o = (counter == STARVE_LIMIT) & !empty; combinational from registered state. A stall cycle always pops.
- Ordering:
  - FIFO entries are written in acceptance order.
  - A same-cycle pipeline write and a FIFO entry to the same rd are not merged; the pipeline issues first, then the FIFO entry writes later. Hazard avoidance is the issue logic's job.

Optional Feature:
- WB_ARB_PERF_EN: when defined, adds two 32-bit outputs, perf_stall_cnt_o and perf_lu_wr_cnt_o.
  - They count stall_o cycles and long-latency writes respectively.
  - Both wrap, reset to 0, and do not change any other behaviour.
- When not defined, the ports and counters are absent.

Decomposition:
- Shared package/define file holds:
  - XLEN, REG_AW and PC_W defaults;
  - the source encodings WB_SRC_PIPE=0 and WB_SRC_LU=1.
- One sub-module: wb_res_fifo, a synchronous FIFO parameterized by width and depth, with full/empty/count and no pass-through.

Test Plan:
- Pipeline only: wr_en=1, rd=5, data=0xDEADBEEF at N -> rf_wr_en=1, addr=5, data=0xDEADBEEF, src=0 at N+1; lu_ready_o stays 1.
- LU into idle slot: lu_valid=1, rd=7, data=0x12 at N, pipeline idle -> rf write of rd=7, data 0x12, src=1 at N+2.
- Starvation: LU entry pushed while pipeline writes rd=1 every cycle, STARVE_LIMIT=4 -> stall_o=1 exactly one cycle 4 cycles after the entry reaches the head; LU write follows; counter clears.
- Full FIFO: 3 back-to-back LU pushes with pipeline busy, depth 2 -> lu_ready_o=0 after the 2nd push; the 3rd is held until a pop; FIFO order is preserved on the output.
- x0 handling: pipeline rd=0 with wr_en=1 while FIFO holds rd=9 -> FIFO pops, writes rd=9 next cycle. LU rd=0 is accepted with no write ever.
- Reset mid-operation: FIFO holds 2 entries, rst=1 for one cycle -> all outputs 0, lu_ready_o=1 after the reset cycle, no stale write afterwards.
